param_icache: RTL and testbench

Parametrised direct-mapped instruction cache. It replaces the single-cycle instruction pass-through inside `caches`. It sits between the datapath instruction port and the memory controller's instruction channel. Hits return data in the same cycle. Misses fill a multi-word block from memory through the `iREN`/`iwait` handshake and then hit.

---
 rtl/param_icache.sv | 136 +++++++++++++
 tb/tb_param_icache.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_icache.sv
// Direct-mapped instruction cache: same-cycle hits, blocking in-order block fills.
// Latency: hit 0 cycles; miss fills WORDS words starting at word 0, then hits.
module param_icache #(
  parameter int SETS  = 16,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IW  = $clog2(SETS);
  localparam int WOB = $clog2(WORDS);
  localparam int KW  = (WOB > 0) ? WOB : 1;
  localparam int TW  = 30 - WOB - IW;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t          state, state_n;
  logic [KW-1:0]   k, k_n;
  logic [TW-1:0]   miss_tag;
  logic [IW-1:0]   miss_idx;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tags [SETS];
  logic [31:0]     data [SETS][WORDS];

  logic [TW-1:0]   tag;
  logic [IW-1:0]   idx;
  logic [KW-1:0]   woff;
  logic [31:0]     fill_addr;
  logic            hit_raw;
  logic            latch;
  logic            fill_we;
  logic            fill_done;
  logic            unused_bits;

  assign unused_bits = ^imemaddr[1:0];
  assign tag = imemaddr[31 -: TW];
  assign idx = imemaddr[2+WOB +: IW];

  generate
    if (WOB > 0) begin : g_woff
      assign woff      = imemaddr[2 +: WOB];
      assign fill_addr = {miss_tag, miss_idx, k, 2'b00};
    end else begin : g_nowoff
      assign woff      = '0;
      assign fill_addr = {miss_tag, miss_idx, 2'b00};
    end
  endgenerate

  assign hit_raw  = valid[idx] && (tags[idx] == tag);
  assign ihit     = imemREN && !iflush && (state == IDLE) && hit_raw;
  assign imemload = ihit ? data[idx][woff] : '0;

  always_comb begin
    state_n   = state;
    k_n       = k;
    latch     = 1'b0;
    fill_we   = 1'b0;
    fill_done = 1'b0;
    iREN      = 1'b0;
    iaddr     = '0;
    if (state == FETCH) begin
      iREN  = 1'b1;
      iaddr = fill_addr;
    end
    // Flush overrides both miss detection and fill progress.
    if (iflush) begin
      state_n = IDLE;
      k_n     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !hit_raw) begin
            latch   = 1'b1;
            k_n     = '0;
            state_n = FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            fill_we = 1'b1;
            if (k == KW'(WORDS - 1)) begin
              fill_done = 1'b1;
              k_n       = '0;
              state_n   = IDLE;
            end else begin
              k_n = k + KW'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      k        <= '0;
      valid    <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      if (latch) begin
        miss_tag <= tag;
        miss_idx <= idx;
      end
      // The victim frame goes invalid as soon as its refill starts.
      if (iflush)
        valid <= '0;
      else if (latch)
        valid[idx] <= 1'b0;
      else if (fill_done)
        valid[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_we)
      data[miss_idx][k] <= iload;
    if (fill_done)
      tags[miss_idx] <= miss_tag;
  end

endmodule

// File: tb/tb_param_icache.sv
// Bench for param_icache: directed scenarios plus random traffic against a block-level model.
module tb_param_icache;
  localparam int SETS  = 16;
  localparam int WORDS = 2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        iflush = 1'b0;
  logic        iwait = 1'b0;
  logic [31:0] iload = 32'h0;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;

  param_icache #(.SETS(SETS), .WORDS(WORDS)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int mem_wcnt = 0;

  // Model: each set remembers which block address it holds.
  bit          m_busy;
  int          m_k;
  logic [31:0] m_base;
  bit          m_valid [SETS];
  logic [31:0] m_blk   [SETS];
  logic [31:0] m_data  [SETS][WORDS];

  logic        o_hit, o_ren, e_hit, e_ren;
  logic [31:0] o_load, o_addr, e_load, e_addr;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return 32'hAAAA0000 + ((a - 32'h100) >> 2) + 32'd1;
  endfunction
  function automatic int set_of(input logic [31:0] a);
    return int'((a / (4 * WORDS)) % SETS);
  endfunction
  function automatic logic [31:0] blk_of(input logic [31:0] a);
    return a - (a % (4 * WORDS));
  endfunction
  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % WORDS);
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_k = 0;
    mem_wcnt = 0;
    for (int i = 0; i < SETS; i++) m_valid[i] = 0;
  endtask

  // One clock cycle: drive inputs, emulate memory, sample outputs, compute expectations, advance model.
  task automatic step(input logic req, input logic [31:0] addr, input logic fl);
    int  s;
    logic w;
    imemREN = req; imemaddr = addr; iflush = fl;
    #1;
    iwait = iREN && (mem_wcnt < wait_n);
    iload = iREN ? mem_val(iaddr) : 32'h0;
    #1;
    o_hit = ihit; o_load = imemload; o_ren = iREN; o_addr = iaddr;
    s = set_of(addr);
    e_hit  = req && !fl && !m_busy && m_valid[s] && (m_blk[s] == blk_of(addr));
    e_load = e_hit ? m_data[s][word_of(addr)] : 32'h0;
    e_ren  = m_busy;
    e_addr = m_busy ? m_base + 32'(4 * m_k) : 32'h0;
    w = iwait;
    @(posedge CLK);
    mem_wcnt = (o_ren && w) ? mem_wcnt + 1 : 0;
    if (fl) begin
      for (int i = 0; i < SETS; i++) m_valid[i] = 0;
      m_busy = 0; m_k = 0;
    end else if (!m_busy) begin
      if (req && !(m_valid[s] && m_blk[s] == blk_of(addr))) begin
        m_busy = 1; m_base = blk_of(addr); m_k = 0;
      end
    end else if (!w) begin
      m_data[set_of(m_base)][m_k] = mem_val(m_base + 32'(4 * m_k));
      m_k++;
      if (m_k == WORDS) begin
        m_valid[set_of(m_base)] = 1;
        m_blk[set_of(m_base)] = m_base;
        m_busy = 0; m_k = 0;
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 0; imemREN = 1; imemaddr = 32'h104;
    @(negedge CLK); #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit: got %b want 0", ihit); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iren: got %b want 0", iREN); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
    checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL reset_load: got %h want 0", imemload); end
    model_reset();
    @(negedge CLK);
    nRST = 1;
  endtask

  task automatic test_cold_miss();
    step(1, 32'h104, 0);
    checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL cold_c0_hit: got %b want 0", o_hit); end
    step(1, 32'h104, 0);
    checks++; if (o_ren !== 1'b1 || o_addr !== 32'h100) begin errors++; $display("FAIL cold_c1: got iren=%b iaddr=%h want 1 00000100", o_ren, o_addr); end
    step(1, 32'h104, 0);
    checks++; if (o_ren !== 1'b1 || o_addr !== 32'h104) begin errors++; $display("FAIL cold_c2: got iren=%b iaddr=%h want 1 00000104", o_ren, o_addr); end
    step(1, 32'h104, 0);
    checks++; if (o_hit !== 1'b1 || o_load !== 32'hAAAA0002) begin errors++; $display("FAIL cold_c3: got hit=%b load=%h want 1 aaaa0002", o_hit, o_load); end
  endtask

  task automatic test_same_block_hit();
    step(1, 32'h100, 0);
    checks++; if (o_hit !== 1'b1 || o_load !== 32'hAAAA0001 || o_ren !== 1'b0) begin
      errors++; $display("FAIL same_block: got hit=%b load=%h iren=%b want 1 aaaa0001 0", o_hit, o_load, o_ren); end
  endtask

  task automatic test_conflict();
    step(1, 32'h180, 0);
    checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL conflict_miss: got %b want 0", o_hit); end
    for (int c = 1; c <= 2; c++) begin
      step(1, 32'h180, 0);
      checks++; if (o_ren !== 1'b1 || o_addr !== 32'h180 + 32'(4 * (c - 1))) begin
        errors++; $display("FAIL conflict_fill%0d: got iren=%b iaddr=%h want 1 %h", c, o_ren, o_addr, 32'h180 + 32'(4 * (c - 1))); end
    end
    step(1, 32'h180, 0);
    checks++; if (o_hit !== 1'b1 || o_load !== mem_val(32'h180)) begin errors++; $display("FAIL conflict_hit: got hit=%b load=%h want 1 %h", o_hit, o_load, mem_val(32'h180)); end
    step(1, 32'h100, 0);
    checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL conflict_evicted: got %b want 0", o_hit); end
    step(1, 32'h100, 0);
    checks++; if (o_ren !== 1'b1 || o_addr !== 32'h100) begin errors++; $display("FAIL conflict_refill: got iren=%b iaddr=%h want 1 00000100", o_ren, o_addr); end
    step(1, 32'h100, 0);
    step(1, 32'h100, 0);
    checks++; if (o_hit !== 1'b1 || o_load !== 32'hAAAA0001) begin errors++; $display("FAIL conflict_rehit: got hit=%b load=%h want 1 aaaa0001", o_hit, o_load); end
  endtask

  task automatic test_wait_states();
    wait_n = 3;
    step(1, 32'h300, 0);
    checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL wait_c0: got %b want 0", o_hit); end
    for (int c = 1; c <= 8; c++) begin
      step(1, 32'h300, 0);
      checks++; if (o_ren !== 1'b1 || o_addr !== ((c <= 4) ? 32'h300 : 32'h304)) begin
        errors++; $display("FAIL wait_c%0d: got iren=%b iaddr=%h want 1 %h", c, o_ren, o_addr, (c <= 4) ? 32'h300 : 32'h304); end
    end
    step(1, 32'h304, 0);
    checks++; if (o_hit !== 1'b1 || o_load !== mem_val(32'h304)) begin errors++; $display("FAIL wait_c9: got hit=%b load=%h want 1 %h", o_hit, o_load, mem_val(32'h304)); end
    wait_n = 0;
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) step(1, 32'h100, 0);
    step(0, 32'h0, 1);
    step(1, 32'h100, 0);
    checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL flush_miss: got %b want 0", o_hit); end
    step(1, 32'h100, 0);
    checks++; if (o_ren !== 1'b1) begin errors++; $display("FAIL flush_iren: got %b want 1", o_ren); end
    step(1, 32'h100, 0);
    step(1, 32'h100, 1);
    checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL flush_with_hit: got %b want 0", o_hit); end
    step(1, 32'h108, 0);
    step(1, 32'h108, 0);
    step(1, 32'h108, 1);
    step(1, 32'h108, 0);
    checks++; if (o_ren !== 1'b0 || o_hit !== 1'b0) begin errors++; $display("FAIL flush_midfill: got iren=%b hit=%b want 0 0", o_ren, o_hit); end
    for (int c = 0; c < 2; c++) step(1, 32'h108, 0);
    step(1, 32'h108, 0);
    checks++; if (o_hit !== 1'b1 || o_load !== mem_val(32'h108)) begin errors++; $display("FAIL flush_refill: got hit=%b load=%h want 1 %h", o_hit, o_load, mem_val(32'h108)); end
    step(1, 32'h110, 0);
    step(1, 32'h110, 0);
    step(1, 32'h114, 1);
    step(1, 32'h114, 0);
    checks++; if (o_hit !== 1'b0 || o_ren !== 1'b0) begin errors++; $display("FAIL flush_last_word: got hit=%b iren=%b want 0 0", o_hit, o_ren); end
    for (int c = 0; c < 2; c++) step(1, 32'h110, 0);
    step(1, 32'h110, 0);
    checks++; if (o_hit !== 1'b1) begin errors++; $display("FAIL flush_last_refill: got %b want 1", o_hit); end
  endtask

  task automatic test_drop_req();
    step(1, 32'h200, 0);
    for (int c = 1; c <= 2; c++) begin
      step(0, $urandom, 0);
      checks++; if (o_ren !== 1'b1 || o_addr !== 32'h200 + 32'(4 * (c - 1))) begin
        errors++; $display("FAIL drop_fill%0d: got iren=%b iaddr=%h want 1 %h", c, o_ren, o_addr, 32'h200 + 32'(4 * (c - 1))); end
    end
    step(1, 32'h204, 0);
    checks++; if (o_hit !== 1'b1 || o_ren !== 1'b0 || o_load !== mem_val(32'h204)) begin
      errors++; $display("FAIL drop_hit: got hit=%b iren=%b load=%h want 1 0 %h", o_hit, o_ren, o_load, mem_val(32'h204)); end
  endtask

  task automatic test_reset_mid_fill();
    step(1, 32'h400, 0);
    step(1, 32'h400, 0);
    nRST = 0;
    #1;
    checks++; if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin
      errors++; $display("FAIL midfill_reset: got iren=%b iaddr=%h hit=%b want 0 0 0", iREN, iaddr, ihit); end
    model_reset();
    @(negedge CLK);
    nRST = 1;
    step(1, 32'h110, 0);
    checks++; if (o_hit !== 1'b0) begin errors++; $display("FAIL midfill_valid_cleared: got %b want 0", o_hit); end
    step(1, 32'h110, 0);
    checks++; if (o_ren !== 1'b1 || o_addr !== 32'h110) begin errors++; $display("FAIL midfill_restart: got iren=%b iaddr=%h want 1 00000110", o_ren, o_addr); end
    step(0, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      wait_n = $urandom_range(0, 2);
      a = (32'($urandom_range(0, 2)) << 7) | (32'($urandom_range(0, 3)) << 3) | (32'($urandom_range(0, 1)) << 2);
      step(($urandom_range(0, 9) < 8), a, ($urandom_range(0, 29) == 0));
      checks++; if (o_hit !== e_hit || o_load !== e_load) begin
        errors++; $display("FAIL rand_hit[%0d]: got hit=%b load=%h want %b %h", n, o_hit, o_load, e_hit, e_load); end
      checks++; if (o_ren !== e_ren || o_addr !== e_addr) begin
        errors++; $display("FAIL rand_mem[%0d]: got iren=%b iaddr=%h want %b %h", n, o_ren, o_addr, e_ren, e_addr); end
    end
    wait_n = 0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_same_block_hit();
    test_conflict();
    test_wait_states();
    test_flush();
    test_drop_req();
    test_reset_mid_fill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
